// File: rtl/comp_seq_ctrl_pkg.sv
// comp_pkg: shared types and constants for the sequential magnitude comparator.
//   state_t   : controller FSM encoding (IDLE, SCAN, DONE)
//   BLOCK_W   : comparator slice width in bits (fixed at 4)
//   num_block : number of slices needed to cover an operand of the given width
package comp_pkg;

  localparam int BLOCK_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_block(input int size);
    return size / BLOCK_W;
  endfunction

endpackage

// File: rtl/comp_seq_ctrl_if.sv
// comp_seq_ctrl_if: operand/result handshake bundle for comp_seq_ctrl.
//
// Handshake rules: a transfer happens on a rising clock edge where the
// producer's valid and the consumer's ready are both 1. A producer keeps
// valid and its payload stable until that edge; ready may change freely.
//
//   i_valid / o_ready / i_data_a / i_data_b : operand pair into the block
//   o_valid / i_ready / o_less / o_equal    : result out of the block
//   o_busy                                  : a scan is in progress
//
// Modports: slave = the comparator block, master = the environment driving it.
interface comp_seq_ctrl_if #(
  parameter int SIZE_DATA = 28
);
  logic                 i_valid;
  logic                 o_ready;
  logic [SIZE_DATA-1:0] i_data_a;
  logic [SIZE_DATA-1:0] i_data_b;
  logic                 o_valid;
  logic                 i_ready;
  logic                 o_less;
  logic                 o_equal;
  logic                 o_busy;

  modport slave (
    input  i_valid, i_data_a, i_data_b, i_ready,
    output o_ready, o_valid, o_less, o_equal, o_busy
  );

  modport master (
    output i_valid, i_data_a, i_data_b, i_ready,
    input  o_ready, o_valid, o_less, o_equal, o_busy
  );
endinterface

// File: rtl/comp_seq_ctrl_comp4.sv
// COMP_4bit: combinational 4-bit unsigned magnitude comparator slice.
//   i_a, i_b : 4-bit slices
//   o_less   : i_a < i_b
//   o_equal  : i_a == i_b
module COMP_4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic       o_less,
  output logic       o_equal
);
  assign o_less  = (i_a < i_b);
  assign o_equal = (i_a == i_b);
endmodule

// File: rtl/comp_seq_ctrl.sv
// comp_seq_ctrl: compares two unsigned SIZE_DATA-bit operands one nibble per
// cycle, most significant nibble first, through one shared COMP_4bit slice.
//
// Ports:
//   i_clk        : clock, rising edge
//   i_rst        : synchronous active-high reset
//   bus          : comp_seq_ctrl_if.slave (operand and result handshakes, busy)
//   o_dbg_state  : current FSM state
//
// Build option COMP_SEQ_EARLY_EXIT_EN:
//   defined   - the scan stops at the first differing nibble (latency 1..NUM_BLOCK)
//   undefined - the scan always covers all nibbles (latency NUM_BLOCK); a sticky
//               flag keeps the most significant difference so results match.
module comp_seq_ctrl #(
  parameter int SIZE_DATA = 28,
  parameter int BLOCK_W   = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  comp_seq_ctrl_if.slave       bus,
  output comp_pkg::state_t     o_dbg_state
);
  import comp_pkg::*;

  localparam int NUM_BLOCK = num_block(SIZE_DATA);
  localparam int IDX_W     = (NUM_BLOCK > 1) ? $clog2(NUM_BLOCK) : 1;

  if ((SIZE_DATA % 4) != 0 || SIZE_DATA < 4) begin : g_size_chk
    $error("comp_seq_ctrl: SIZE_DATA must be a positive multiple of 4");
  end
  if (BLOCK_W != comp_pkg::BLOCK_W) begin : g_blk_chk
    $error("comp_seq_ctrl: BLOCK_W must be 4");
  end

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [SIZE_DATA-1:0] a_q, a_d, b_q, b_d;
  logic                 less_q, less_d, equal_q, equal_d;
  logic                 valid_q, valid_d, ready_q, ready_d, busy_q, busy_d;
`ifndef COMP_SEQ_EARLY_EXIT_EN
  logic                 decided_q, decided_d, dec_less_q, dec_less_d;
`endif

  // idx-selected nibble of each registered operand
  logic [SIZE_DATA-1:0] a_sh, b_sh;
  logic                 slice_less, slice_equal;

  assign a_sh = a_q >> {idx_q, 2'b00};
  assign b_sh = b_q >> {idx_q, 2'b00};

  COMP_4bit u_slice (
    .i_a     (a_sh[3:0]),
    .i_b     (b_sh[3:0]),
    .o_less  (slice_less),
    .o_equal (slice_equal)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    less_d  = less_q;
    equal_d = equal_q;
    valid_d = valid_q;
    ready_d = ready_q;
    busy_d  = busy_q;
`ifndef COMP_SEQ_EARLY_EXIT_EN
    decided_d  = decided_q;
    dec_less_d = dec_less_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.i_valid && ready_q) begin
          a_d     = bus.i_data_a;
          b_d     = bus.i_data_b;
          idx_d   = IDX_W'(NUM_BLOCK - 1);
          state_d = SCAN;
          ready_d = 1'b0;
          busy_d  = 1'b1;
`ifndef COMP_SEQ_EARLY_EXIT_EN
          decided_d  = 1'b0;
          dec_less_d = 1'b0;
`endif
        end
      end
      SCAN: begin
`ifdef COMP_SEQ_EARLY_EXIT_EN
        if (!slice_equal || idx_q == '0) begin
          less_d  = slice_less;
          equal_d = slice_equal;
          state_d = DONE;
          valid_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
`else
        // Only the first (most significant) difference may set the verdict.
        if (!decided_q && !slice_equal) begin
          decided_d  = 1'b1;
          dec_less_d = slice_less;
        end
        if (idx_q == '0) begin
          if (decided_q) begin
            less_d  = dec_less_q;
            equal_d = 1'b0;
          end else begin
            less_d  = slice_less;
            equal_d = slice_equal;
          end
          state_d = DONE;
          valid_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
`endif
      end
      DONE: begin
        if (bus.i_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      less_q  <= 1'b0;
      equal_q <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
`ifndef COMP_SEQ_EARLY_EXIT_EN
      decided_q  <= 1'b0;
      dec_less_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      less_q  <= less_d;
      equal_q <= equal_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
`ifndef COMP_SEQ_EARLY_EXIT_EN
      decided_q  <= decided_d;
      dec_less_q <= dec_less_d;
`endif
    end
  end

  assign bus.o_ready  = ready_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_less   = less_q;
  assign bus.o_equal  = equal_q;
  assign bus.o_busy   = busy_q;
  assign o_dbg_state  = state_q;

endmodule
